// File: rtl/soccer_pkg.sv
// soccer_pkg
// Shared types and default playfield constants for the soccer game blocks
// (ball physics, goal detection, rendering).
//   side_t       : which goal was scored into (none / left / right)
//   goal_state_t : goal-detector sequencing states
//   DEF_*        : default screen / goal geometry used across blocks
package soccer_pkg;

    typedef enum logic [1:0] {
        SIDE_NONE,
        SIDE_LEFT,
        SIDE_RIGHT
    } side_t;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_CONFIRM,
        ST_CELEBRATE,
        ST_RESPAWN
    } goal_state_t;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_GOAL_W      = 40;
    localparam int DEF_GOAL_TOP    = 320;
    localparam int DEF_BALL_SIZE   = 16;
    localparam int DEF_HOLD_FRAMES = 60;
    localparam int DEF_POS_W       = 10;

endpackage

// File: rtl/goal_detector_if.sv
// goal_detector_if
// Bundles the per-frame ball position coming from the physics block and the
// goal/freeze/respawn signals going back to physics and the scoreboard.
//   master : upstream/environment side (drives tick, active flag, position)
//   slave  : goal_detector side (drives goal pulses, freeze, respawn, scorer)
interface goal_detector_if
    import soccer_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
);
    logic             frame_tick;
    logic             game_active;
    logic [POS_W-1:0] ball_x;
    logic [POS_W-1:0] ball_y;
    logic             goal_player1;
    logic             goal_player2;
    logic             freeze;
    logic             ball_reset;
    side_t            last_scorer;

    modport master (
        output frame_tick, game_active, ball_x, ball_y,
        input  goal_player1, goal_player2, freeze, ball_reset, last_scorer
    );

    modport slave (
        input  frame_tick, game_active, ball_x, ball_y,
        output goal_player1, goal_player2, freeze, ball_reset, last_scorer
    );

endinterface

// File: rtl/goal_detector_zone_cmp.sv
// goal_zone_cmp
// Purely combinational goal-mouth test for one side of the pitch.
//   Left side : ball right edge (x + BALL_SIZE) <= EDGE_X and y >= GOAL_TOP
//   Right side: ball left edge  x               >= EDGE_X and y >= GOAL_TOP
// Ports:
//   i_ball_x, i_ball_y : ball top-left corner
//   o_in_zone          : ball lies fully inside this goal mouth
module goal_zone_cmp #(
    parameter int POS_W     = 10,
    parameter bit IS_LEFT   = 1'b1,
    parameter int EDGE_X    = 40,
    parameter int GOAL_TOP  = 320,
    parameter int BALL_SIZE = 16
) (
    input  logic [POS_W-1:0] i_ball_x,
    input  logic [POS_W-1:0] i_ball_y,
    output logic             o_in_zone
);
    // One extra bit so x + BALL_SIZE can never wrap.
    localparam logic [POS_W:0] C_EDGE = (POS_W+1)'(EDGE_X);
    localparam logic [POS_W:0] C_TOP  = (POS_W+1)'(GOAL_TOP);
    localparam logic [POS_W:0] C_SIZE = (POS_W+1)'(BALL_SIZE);

    logic [POS_W:0] w_x_ext;
    logic [POS_W:0] w_far_x;
    logic           w_y_ok;

    always_comb begin
        w_x_ext = {1'b0, i_ball_x};
        w_far_x = w_x_ext + C_SIZE;
        w_y_ok  = ({1'b0, i_ball_y} >= C_TOP);
        if (IS_LEFT) begin
            o_in_zone = (w_far_x <= C_EDGE) && w_y_ok;
        end else begin
            o_in_zone = (w_x_ext >= C_EDGE) && w_y_ok;
        end
    end

endmodule

// File: rtl/goal_detector.sv
// goal_detector
// Turns per-frame ball position into scoreboard goal events. A goal needs two
// consecutive qualifying frame ticks on the same side; it then emits a
// one-cycle goal pulse, freezes play for HOLD_FRAMES ticks and requests a
// one-cycle ball respawn.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : goal_detector_if.slave
//           in : frame_tick, game_active, ball_x, ball_y
//           out: goal_player1 (right goal), goal_player2 (left goal),
//                freeze, ball_reset, last_scorer (all registered)
module goal_detector
    import soccer_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int GOAL_W      = DEF_GOAL_W,
    parameter int GOAL_TOP    = DEF_GOAL_TOP,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int POS_W       = DEF_POS_W
) (
    input  logic          clk,
    input  logic          reset,
    goal_detector_if.slave bus
);
    localparam int                CNT_W       = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_FRAMES - 1);

    goal_state_t      r_state,  w_state_nxt;
    side_t            r_side,   w_side_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_goal_p1, w_goal_p1_nxt;
    logic             r_goal_p2, w_goal_p2_nxt;
    logic             r_freeze,  w_freeze_nxt;
    logic             r_ball_reset, w_ball_reset_nxt;
    side_t            r_last,    w_last_nxt;

    logic w_in_left;
    logic w_in_right_raw;
    logic w_in_right;
    logic w_still_in;

    goal_zone_cmp #(
        .POS_W     (POS_W),
        .IS_LEFT   (1'b1),
        .EDGE_X    (GOAL_W),
        .GOAL_TOP  (GOAL_TOP),
        .BALL_SIZE (BALL_SIZE)
    ) u_zone_left (
        .i_ball_x  (bus.ball_x),
        .i_ball_y  (bus.ball_y),
        .o_in_zone (w_in_left)
    );

    goal_zone_cmp #(
        .POS_W     (POS_W),
        .IS_LEFT   (1'b0),
        .EDGE_X    (SCREEN_W - GOAL_W),
        .GOAL_TOP  (GOAL_TOP),
        .BALL_SIZE (BALL_SIZE)
    ) u_zone_right (
        .i_ball_x  (bus.ball_x),
        .i_ball_y  (bus.ball_y),
        .o_in_zone (w_in_right_raw)
    );

    // Left wins if a narrow pitch ever lets both tests pass together.
    assign w_in_right = w_in_right_raw & ~w_in_left;

    assign w_still_in = ((r_side == SIDE_LEFT)  && w_in_left) ||
                        ((r_side == SIDE_RIGHT) && w_in_right);

    always_comb begin
        w_state_nxt      = r_state;
        w_side_nxt       = r_side;
        w_cnt_nxt        = r_cnt;
        w_goal_p1_nxt    = 1'b0;
        w_goal_p2_nxt    = 1'b0;
        w_ball_reset_nxt = 1'b0;
        w_last_nxt       = r_last;

        if (!bus.game_active) begin
            // Abort: drop any sequence silently, keep the last scorer.
            w_state_nxt = ST_PLAY;
            w_side_nxt  = SIDE_NONE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        if (w_in_left) begin
                            w_side_nxt  = SIDE_LEFT;
                            w_state_nxt = ST_CONFIRM;
                        end else if (w_in_right) begin
                            w_side_nxt  = SIDE_RIGHT;
                            w_state_nxt = ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (bus.frame_tick) begin
                        if (w_still_in) begin
                            w_state_nxt = ST_CELEBRATE;
                            w_cnt_nxt   = C_HOLD_LOAD;
                            w_last_nxt  = r_side;
                            // Player 1 attacks the right goal.
                            w_goal_p1_nxt = (r_side == SIDE_RIGHT);
                            w_goal_p2_nxt = (r_side == SIDE_LEFT);
                        end else begin
                            // A ball now in the opposite goal does not
                            // re-arm on this tick; it must qualify twice
                            // starting from PLAY.
                            w_state_nxt = ST_PLAY;
                            w_side_nxt  = SIDE_NONE;
                        end
                    end
                end
                ST_CELEBRATE: begin
                    if (bus.frame_tick) begin
                        if (r_cnt == '0) begin
                            w_state_nxt      = ST_RESPAWN;
                            w_ball_reset_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_RESPAWN: begin
                    w_state_nxt = ST_PLAY;
                    w_side_nxt  = SIDE_NONE;
                end
                default: begin
                    w_state_nxt = ST_PLAY;
                    w_side_nxt  = SIDE_NONE;
                end
            endcase
        end

        w_freeze_nxt = (w_state_nxt == ST_CELEBRATE) ||
                       (w_state_nxt == ST_RESPAWN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_PLAY;
            r_side       <= SIDE_NONE;
            r_cnt        <= '0;
            r_goal_p1    <= 1'b0;
            r_goal_p2    <= 1'b0;
            r_freeze     <= 1'b0;
            r_ball_reset <= 1'b0;
            r_last       <= SIDE_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_side       <= w_side_nxt;
            r_cnt        <= w_cnt_nxt;
            r_goal_p1    <= w_goal_p1_nxt;
            r_goal_p2    <= w_goal_p2_nxt;
            r_freeze     <= w_freeze_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_last       <= w_last_nxt;
        end
    end

    assign bus.goal_player1 = r_goal_p1;
    assign bus.goal_player2 = r_goal_p2;
    assign bus.freeze       = r_freeze;
    assign bus.ball_reset   = r_ball_reset;
    assign bus.last_scorer  = r_last;

endmodule

// File: tb/tb_goal_detector.sv
// tb_goal_detector
// Directed, table-driven bench for goal_detector with default parameters.
module tb_goal_detector;
    import soccer_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    goal_detector_if #(.POS_W(10)) bus ();

    goal_detector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       g1;
        logic       g2;
        logic [1:0] last;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Drive one frame tick; returns just after the negedge following the
    // capturing posedge, so registered outputs for that tick are visible.
    task automatic do_tick(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.ball_x     = x;
        bus.ball_y     = y;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic abort_seq();
        @(negedge clk);
        bus.game_active = 1'b0;
        @(negedge clk);
        bus.game_active = 1'b1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_g1"},  32'(bus.goal_player1), 32'd0);
        chk({nm, "_g2"},  32'(bus.goal_player2), 32'd0);
        chk({nm, "_frz"}, 32'(bus.freeze),       32'd0);
        chk({nm, "_br"},  32'(bus.ball_reset),   32'd0);
    endtask

    initial begin
        int bad;
        checks   = 0;
        failures = 0;

        //            x     y    g1    g2    last
        vecs[0] = '{10'd10,  10'd330, 1'b0, 1'b1, 2'(SIDE_LEFT)};
        vecs[1] = '{10'd600, 10'd400, 1'b1, 1'b0, 2'(SIDE_RIGHT)};
        vecs[2] = '{10'd24,  10'd320, 1'b0, 1'b1, 2'(SIDE_LEFT)};
        vecs[3] = '{10'd25,  10'd320, 1'b0, 1'b0, 2'(SIDE_LEFT)};
        vecs[4] = '{10'd10,  10'd319, 1'b0, 1'b0, 2'(SIDE_LEFT)};
        vecs[5] = '{10'd600, 10'd319, 1'b0, 1'b0, 2'(SIDE_LEFT)};
        vecs[6] = '{10'd599, 10'd400, 1'b0, 1'b0, 2'(SIDE_LEFT)};
        vecs[7] = '{10'd624, 10'd479, 1'b1, 1'b0, 2'(SIDE_RIGHT)};
        vecs[8] = '{10'd0,   10'd1023, 1'b0, 1'b1, 2'(SIDE_LEFT)};

        reset           = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.game_active = 1'b1;
        bus.ball_x      = 10'd320;
        bus.ball_y      = 10'd100;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_last", 32'(bus.last_scorer), 32'(SIDE_NONE));
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_tick(vecs[i].x, vecs[i].y);
            chk($sformatf("v%0d_t1_frz", i), 32'(bus.freeze), 32'd0);
            do_tick(vecs[i].x, vecs[i].y);
            chk($sformatf("v%0d_g1", i),   32'(bus.goal_player1), 32'(vecs[i].g1));
            chk($sformatf("v%0d_g2", i),   32'(bus.goal_player2), 32'(vecs[i].g2));
            chk($sformatf("v%0d_frz", i),  32'(bus.freeze),       32'(vecs[i].g1 | vecs[i].g2));
            chk($sformatf("v%0d_last", i), 32'(bus.last_scorer),  32'(vecs[i].last));
            abort_seq();
        end

        // Full left goal with celebration and respawn.
        do_tick(10'd10, 10'd330);
        do_tick(10'd10, 10'd330);
        chk("full_g2", 32'(bus.goal_player2), 32'd1);
        @(negedge clk);
        chk("full_g2_one_cycle", 32'(bus.goal_player2), 32'd0);
        chk("full_frz_hold", 32'(bus.freeze), 32'd1);
        bad = 0;
        for (int t = 0; t < 59; t++) begin
            do_tick(10'd320, 10'd100);
            if (bus.ball_reset !== 1'b0 || bus.freeze !== 1'b1) bad++;
        end
        chk("full_celebrate_59", 32'(bad), 32'd0);
        do_tick(10'd320, 10'd100);
        chk("full_br", 32'(bus.ball_reset), 32'd1);
        chk("full_br_frz", 32'(bus.freeze), 32'd1);
        @(negedge clk);
        chk("full_br_one_cycle", 32'(bus.ball_reset), 32'd0);
        chk("full_frz_drop", 32'(bus.freeze), 32'd0);
        chk("full_last", 32'(bus.last_scorer), 32'(SIDE_LEFT));

        // Bounce-out, then re-arm from PLAY.
        do_tick(10'd10, 10'd330);
        do_tick(10'd100, 10'd330);
        chk_idle("bounce");
        do_tick(10'd10, 10'd330);
        chk_idle("bounce_rearm1");
        do_tick(10'd10, 10'd330);
        chk("bounce_goal", 32'(bus.goal_player2), 32'd1);
        abort_seq();

        // Opposite goal during CONFIRM must not re-arm on that tick.
        do_tick(10'd10, 10'd330);
        do_tick(10'd600, 10'd400);
        chk_idle("opp_t2");
        do_tick(10'd600, 10'd400);
        chk_idle("opp_t3");
        do_tick(10'd600, 10'd400);
        chk("opp_g1", 32'(bus.goal_player1), 32'd1);
        chk("opp_last", 32'(bus.last_scorer), 32'(SIDE_RIGHT));
        abort_seq();

        // Abort mid-celebration.
        do_tick(10'd10, 10'd330);
        do_tick(10'd10, 10'd330);
        chk("abort_g2", 32'(bus.goal_player2), 32'd1);
        for (int t = 0; t < 29; t++) do_tick(10'd320, 10'd100);
        chk("abort_frz_before", 32'(bus.freeze), 32'd1);
        @(negedge clk);
        bus.game_active = 1'b0;
        @(negedge clk);
        chk("abort_frz", 32'(bus.freeze), 32'd0);
        chk("abort_last", 32'(bus.last_scorer), 32'(SIDE_LEFT));
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (bus.ball_reset !== 1'b0) bad++;
        end
        bus.game_active = 1'b1;
        for (int t = 0; t < 40; t++) begin
            do_tick(10'd320, 10'd100);
            if (bus.ball_reset !== 1'b0 || bus.freeze !== 1'b0) bad++;
        end
        chk("abort_no_br", 32'(bad), 32'd0);

        // Asynchronous reset mid-celebration.
        do_tick(10'd600, 10'd400);
        do_tick(10'd600, 10'd400);
        chk("rstmid_g1", 32'(bus.goal_player1), 32'd1);
        for (int t = 0; t < 5; t++) do_tick(10'd320, 10'd100);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_idle("rstmid");
        chk("rstmid_last", 32'(bus.last_scorer), 32'(SIDE_NONE));
        @(negedge clk);
        reset = 1'b0;
        do_tick(10'd10, 10'd330);
        chk_idle("fresh_t1");
        do_tick(10'd10, 10'd330);
        chk("fresh_g2", 32'(bus.goal_player2), 32'd1);
        chk("fresh_frz", 32'(bus.freeze), 32'd1);
        chk("fresh_last", 32'(bus.last_scorer), 32'(SIDE_LEFT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
